// File: rtl/ucode_sequencer.sv
// ---------------------------------------------------------------------------
// ucode_sequencer
//
// Expands the MULI macro instruction (rd = rs1 * imm) into a shift-and-add
// micro-op stream that uses two reserved scratch registers, TMP_A and TMP_B:
//
//    MOVI TMP_A, #0
//    for each set bit i of imm, lowest first:
//       LSL  TMP_B, rs1, #i
//       ADD  TMP_A, TMP_A, TMP_B
//    ADD  rd, TMP_A, #0            (uop_last)
//
// Ports
//    clk, rst          core clock, synchronous active-low reset
//    clk_en            global enable; when low every flop holds
//    macro_*           macro instruction from fetch (valid/ready handshake)
//    uop_*             registered micro-op to decode/execute (valid/ready)
//    busy              high while a macro is being expanded (fetch stalls)
//    done              one-cycle pulse after the final micro-op is accepted
//    err               one-cycle pulse after a rejected macro
// ---------------------------------------------------------------------------
module ucode_sequencer #(
   parameter int unsigned IMM_W    = 16,
   parameter logic [6:0]  OPC_MULI = 7'h2A,
   parameter logic [3:0]  TMP_A    = 4'd14,
   parameter logic [3:0]  TMP_B    = 4'd15,
   parameter logic [2:0]  ALU_ADD  = 3'd0,
   parameter logic [2:0]  ALU_LSL  = 3'd5,
   parameter logic [2:0]  ALU_MOVI = 3'd7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             macro_valid,
   input  logic [6:0]       macro_opcode,
   input  logic [3:0]       macro_rd,
   input  logic [3:0]       macro_rs1,
   input  logic [IMM_W-1:0] macro_imm,
   output logic             macro_ready,
   output logic             uop_valid,
   input  logic             uop_ready,
   output logic [2:0]       uop_alu,
   output logic [3:0]       uop_rd,
   output logic [3:0]       uop_rs1,
   output logic [3:0]       uop_rs2,
   output logic [IMM_W-1:0] uop_imm,
   output logic             uop_use_imm,
   output logic             uop_last,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_SHIFT,
      ST_ACC,
      ST_COPY
   } state_t;

   state_t           state_q, state_d;
   logic [IMM_W-1:0] m_q, m_d;
   logic [3:0]       rd_q, rd_d;
   logic [3:0]       rs1_q, rs1_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             uop_valid_q, uop_valid_d;
   logic [2:0]       uop_alu_q, uop_alu_d;
   logic [3:0]       uop_rd_q, uop_rd_d;
   logic [3:0]       uop_rs1_q, uop_rs1_d;
   logic [3:0]       uop_rs2_q, uop_rs2_d;
   logic [IMM_W-1:0] uop_imm_q, uop_imm_d;
   logic             uop_use_imm_q, uop_use_imm_d;
   logic             uop_last_q, uop_last_d;

   logic             accept;
   logic             macro_bad;
   logic             uop_fire;
   logic [IMM_W-1:0] m_clear;
   logic [IMM_W-1:0] lsb_idx;

   // Sequencing: handshakes, mask update and next state.
   always_comb begin
      accept    = macro_valid && (state_q == ST_IDLE) && clk_en;
      macro_bad = (macro_opcode != OPC_MULI)
                  || (macro_rs1 == TMP_A) || (macro_rs1 == TMP_B)
                  || (macro_rd == TMP_A)  || (macro_rd == TMP_B);
      uop_fire  = uop_valid_q && uop_ready && clk_en;
      // Clearing the lowest set bit moves the scan to the next multiplier bit.
      m_clear   = m_q & (m_q - IMM_W'(1));

      state_d = state_q;
      m_d     = m_q;
      rd_d    = rd_q;
      rs1_d   = rs1_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rd_d  = macro_rd;
               rs1_d = macro_rs1;
               m_d   = macro_imm;
               if (macro_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_CLR;
               end
            end
         end
         ST_CLR: begin
            if (uop_fire) begin
               state_d = (m_q == '0) ? ST_COPY : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (uop_fire) begin
               state_d = ST_ACC;
            end
         end
         ST_ACC: begin
            if (uop_fire) begin
               m_d     = m_clear;
               state_d = (m_clear == '0) ? ST_COPY : ST_SHIFT;
            end
         end
         ST_COPY: begin
            if (uop_fire) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Lowest set bit of the upcoming mask; scanning downwards lets the
   // lowest index overwrite any higher one.
   always_comb begin
      lsb_idx = '0;
      for (int k = IMM_W - 1; k >= 0; k--) begin
         if (m_d[k]) begin
            lsb_idx = IMM_W'(k);
         end
      end
   end

   // Micro-op fields are decoded from the upcoming state so that they are
   // registered alongside it; while stalled the inputs to this decode do not
   // change, so the fields stay stable.
   always_comb begin
      uop_valid_d   = (state_d != ST_IDLE);
      uop_alu_d     = '0;
      uop_rd_d      = '0;
      uop_rs1_d     = '0;
      uop_rs2_d     = '0;
      uop_imm_d     = '0;
      uop_use_imm_d = 1'b0;
      uop_last_d    = 1'b0;

      case (state_d)
         ST_CLR: begin
            uop_alu_d     = ALU_MOVI;
            uop_rd_d      = TMP_A;
            uop_use_imm_d = 1'b1;
         end
         ST_SHIFT: begin
            uop_alu_d     = ALU_LSL;
            uop_rd_d      = TMP_B;
            uop_rs1_d     = rs1_d;
            uop_imm_d     = lsb_idx;
            uop_use_imm_d = 1'b1;
         end
         ST_ACC: begin
            uop_alu_d = ALU_ADD;
            uop_rd_d  = TMP_A;
            uop_rs1_d = TMP_A;
            uop_rs2_d = TMP_B;
         end
         ST_COPY: begin
            uop_alu_d     = ALU_ADD;
            uop_rd_d      = rd_d;
            uop_rs1_d     = TMP_A;
            uop_use_imm_d = 1'b1;
            uop_last_d    = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Reset overrides clk_en; otherwise nothing moves while clk_en is low,
   // which also stretches done/err pulses until the next enabled edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         m_q           <= '0;
         rd_q          <= '0;
         rs1_q         <= '0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         uop_valid_q   <= 1'b0;
         uop_alu_q     <= '0;
         uop_rd_q      <= '0;
         uop_rs1_q     <= '0;
         uop_rs2_q     <= '0;
         uop_imm_q     <= '0;
         uop_use_imm_q <= 1'b0;
         uop_last_q    <= 1'b0;
      end else if (clk_en) begin
         state_q       <= state_d;
         m_q           <= m_d;
         rd_q          <= rd_d;
         rs1_q         <= rs1_d;
         done_q        <= done_d;
         err_q         <= err_d;
         uop_valid_q   <= uop_valid_d;
         uop_alu_q     <= uop_alu_d;
         uop_rd_q      <= uop_rd_d;
         uop_rs1_q     <= uop_rs1_d;
         uop_rs2_q     <= uop_rs2_d;
         uop_imm_q     <= uop_imm_d;
         uop_use_imm_q <= uop_use_imm_d;
         uop_last_q    <= uop_last_d;
      end
   end

   assign macro_ready = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign err         = err_q;
   assign uop_valid   = uop_valid_q;
   assign uop_alu     = uop_alu_q;
   assign uop_rd      = uop_rd_q;
   assign uop_rs1     = uop_rs1_q;
   assign uop_rs2     = uop_rs2_q;
   assign uop_imm     = uop_imm_q;
   assign uop_use_imm = uop_use_imm_q;
   assign uop_last    = uop_last_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ucode_sequencer
//
// Table of macro instructions with their expected outcome (rejected, or the
// number of micro-ops). For accepted macros the bench's own shift-and-add
// model pushes the expected micro-op stream onto a scoreboard queue; each
// accepted micro-op pops and compares. Hand-written sequences cover reset
// in the middle of an expansion and macros offered while clk_en is low.
// ---------------------------------------------------------------------------
module tb_ucode_sequencer;

   localparam int IMM_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             clk_en;
   logic             macro_valid;
   logic [6:0]       macro_opcode;
   logic [3:0]       macro_rd;
   logic [3:0]       macro_rs1;
   logic [IMM_W-1:0] macro_imm;
   logic             macro_ready;
   logic             uop_valid;
   logic             uop_ready;
   logic [2:0]       uop_alu;
   logic [3:0]       uop_rd;
   logic [3:0]       uop_rs1;
   logic [3:0]       uop_rs2;
   logic [IMM_W-1:0] uop_imm;
   logic             uop_use_imm;
   logic             uop_last;
   logic             busy;
   logic             done;
   logic             err;

   always #5 clk = ~clk;

   ucode_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .clk_en       (clk_en),
      .macro_valid  (macro_valid),
      .macro_opcode (macro_opcode),
      .macro_rd     (macro_rd),
      .macro_rs1    (macro_rs1),
      .macro_imm    (macro_imm),
      .macro_ready  (macro_ready),
      .uop_valid    (uop_valid),
      .uop_ready    (uop_ready),
      .uop_alu      (uop_alu),
      .uop_rd       (uop_rd),
      .uop_rs1      (uop_rs1),
      .uop_rs2      (uop_rs2),
      .uop_imm      (uop_imm),
      .uop_use_imm  (uop_use_imm),
      .uop_last     (uop_last),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   typedef struct packed {
      logic [2:0]       alu;
      logic [3:0]       rd;
      logic [3:0]       rs1;
      logic [3:0]       rs2;
      logic [IMM_W-1:0] imm;
      logic             use_imm;
      logic             last;
   } uop_t;

   typedef struct {
      logic [6:0]       opc;
      logic [3:0]       rd;
      logic [3:0]       rs1;
      logic [IMM_W-1:0] imm;
      int               stall_idx;
      int               stall_len;
      int               freeze_idx;
      bit               spam;
      bit               exp_err;
      int               exp_len;
   } vec_t;

   uop_t exp_q[$];
   vec_t vecs[9];
   int   checks   = 0;
   int   failures = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   function automatic uop_t mk_uop(input logic [2:0] alu, input logic [3:0] rd,
                                   input logic [3:0] rs1, input logic [3:0] rs2,
                                   input logic [IMM_W-1:0] imm,
                                   input logic use_imm, input logic last);
      uop_t u;
      u.alu     = alu;
      u.rd      = rd;
      u.rs1     = rs1;
      u.rs2     = rs2;
      u.imm     = imm;
      u.use_imm = use_imm;
      u.last    = last;
      return u;
   endfunction

   function automatic uop_t dut_uop();
      return {uop_alu, uop_rd, uop_rs1, uop_rs2, uop_imm, uop_use_imm, uop_last};
   endfunction

   function automatic vec_t mk_vec(input logic [6:0] opc, input logic [3:0] rd,
                                   input logic [3:0] rs1, input logic [IMM_W-1:0] imm,
                                   input int stall_idx, input int stall_len,
                                   input int freeze_idx, input bit spam,
                                   input bit exp_err, input int exp_len);
      vec_t v;
      v.opc        = opc;
      v.rd         = rd;
      v.rs1        = rs1;
      v.imm        = imm;
      v.stall_idx  = stall_idx;
      v.stall_len  = stall_len;
      v.freeze_idx = freeze_idx;
      v.spam       = spam;
      v.exp_err    = exp_err;
      v.exp_len    = exp_len;
      return v;
   endfunction

   // Reference model: MOVI, then LSL/ADD per set bit from bit 0 upwards, then copy.
   task automatic push_expected(input logic [3:0] rd, input logic [3:0] rs1,
                                input logic [IMM_W-1:0] imm);
      exp_q.push_back(mk_uop(3'd7, 4'd14, 4'd0, 4'd0, '0, 1'b1, 1'b0));
      for (int k = 0; k < IMM_W; k++) begin
         if (imm[k]) begin
            exp_q.push_back(mk_uop(3'd5, 4'd15, rs1, 4'd0, 16'(k), 1'b1, 1'b0));
            exp_q.push_back(mk_uop(3'd0, 4'd14, 4'd14, 4'd15, '0, 1'b0, 1'b0));
         end
      end
      exp_q.push_back(mk_uop(3'd0, rd, 4'd14, 4'd0, '0, 1'b1, 1'b1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_macro_ready"}, macro_ready, 1);
      check_output({tag, "_uop_valid"}, uop_valid, 0);
      check_output({tag, "_uop_fields"}, dut_uop(), 0);
      check_output({tag, "_busy"}, busy, 0);
      check_output({tag, "_done"}, done, 0);
      check_output({tag, "_err"}, err, 0);
   endtask

   task automatic apply_stimulus(input vec_t v);
      int   cycles;
      int   idx;
      int   stall_left;
      int   freeze_left;
      int   freeze_len;
      uop_t exp;
      check_output("macro_ready_before", macro_ready, 1);
      macro_opcode = v.opc;
      macro_rd     = v.rd;
      macro_rs1    = v.rs1;
      macro_imm    = v.imm;
      macro_valid  = 1'b1;
      uop_ready    = 1'b1;
      clk_en       = 1'b1;
      tick();
      macro_valid = 1'b0;
      if (v.exp_err) begin
         check_output("err_pulse", err, 1);
         check_output("err_uop_valid", uop_valid, 0);
         check_output("err_busy", busy, 0);
         check_output("err_macro_ready", macro_ready, 1);
         tick();
         check_output("err_cleared", err, 0);
         check_output("err_uop_valid_after", uop_valid, 0);
         check_output("err_busy_after", busy, 0);
         return;
      end
      push_expected(v.rd, v.rs1, v.imm);
      check_output("busy_after_accept", busy, 1);
      check_output("macro_ready_after_accept", macro_ready, 0);
      cycles      = 0;
      idx         = 0;
      stall_left  = v.stall_len;
      freeze_len  = (v.freeze_idx >= 0) ? 2 : 0;
      freeze_left = freeze_len;
      while (exp_q.size() > 0 && cycles < 200) begin
         exp = exp_q[0];
         check_output($sformatf("uop_valid[%0d]", idx), uop_valid, 1);
         check_output($sformatf("uop_fields[%0d]", idx), dut_uop(), exp);
         macro_valid = v.spam;
         clk_en      = 1'b1;
         uop_ready   = 1'b1;
         if (idx == v.stall_idx && stall_left > 0) begin
            uop_ready = 1'b0;
            stall_left--;
         end else if (idx == v.freeze_idx && freeze_left > 0) begin
            clk_en = 1'b0;
            freeze_left--;
         end
         if (uop_valid && uop_ready && clk_en) begin
            void'(exp_q.pop_front());
            idx++;
         end
         tick();
         cycles++;
      end
      macro_valid = 1'b0;
      clk_en      = 1'b1;
      uop_ready   = 1'b1;
      if (exp_q.size() > 0) begin
         check_output("seq_timeout_remaining", exp_q.size(), 0);
         exp_q.delete();
      end
      check_output("seq_cycles", cycles, v.exp_len + v.stall_len + freeze_len);
      check_output("done_pulse", done, 1);
      check_output("end_uop_valid", uop_valid, 0);
      check_output("end_macro_ready", macro_ready, 1);
      check_output("end_busy", busy, 0);
      clk_en = 1'b0;
      tick();
      check_output("done_held_clk_en_low", done, 1);
      clk_en = 1'b1;
      tick();
      check_output("done_cleared", done, 0);
   endtask

   initial begin
      // {opc, rd, rs1, imm, stall_idx, stall_len, freeze_idx, spam, exp_err, exp_len}
      vecs[0] = mk_vec(7'h2A, 4'd3, 4'd2, 16'h0005, -1, 0, -1, 1'b0, 1'b0, 6);
      vecs[1] = mk_vec(7'h2A, 4'd5, 4'd1, 16'h0000, -1, 0, -1, 1'b0, 1'b0, 2);
      vecs[2] = mk_vec(7'h2A, 4'd7, 4'd13, 16'hFFFF, -1, 0, -1, 1'b0, 1'b0, 34);
      vecs[3] = mk_vec(7'h2A, 4'd1, 4'd4, 16'h0006, 1, 3, -1, 1'b0, 1'b0, 6);
      vecs[4] = mk_vec(7'h2A, 4'd9, 4'd0, 16'h00F0, -1, 0, 3, 1'b1, 1'b0, 10);
      vecs[5] = mk_vec(7'h11, 4'd3, 4'd2, 16'h0005, -1, 0, -1, 1'b0, 1'b1, 0);
      vecs[6] = mk_vec(7'h2A, 4'd3, 4'd15, 16'h0005, -1, 0, -1, 1'b0, 1'b1, 0);
      vecs[7] = mk_vec(7'h2A, 4'd14, 4'd2, 16'h0005, -1, 0, -1, 1'b0, 1'b1, 0);
      vecs[8] = mk_vec(7'h2A, 4'd0, 4'd12, 16'h8001, -1, 0, -1, 1'b1, 1'b0, 6);

      rst          = 1'b0;
      clk_en       = 1'b0;
      macro_valid  = 1'b0;
      macro_opcode = '0;
      macro_rd     = '0;
      macro_rs1    = '0;
      macro_imm    = '0;
      uop_ready    = 1'b1;
      tick();
      tick();
      check_reset_outputs("reset");
      rst    = 1'b1;
      clk_en = 1'b1;
      tick();

      // A macro offered while clk_en is low must not be taken.
      macro_opcode = 7'h2A;
      macro_rd     = 4'd2;
      macro_rs1    = 4'd1;
      macro_imm    = 16'h0001;
      macro_valid  = 1'b1;
      clk_en       = 1'b0;
      tick();
      macro_valid = 1'b0;
      clk_en      = 1'b1;
      check_output("no_accept_clk_en_low_busy", busy, 0);
      check_output("no_accept_clk_en_low_valid", uop_valid, 0);
      tick();

      for (int i = 0; i < 9; i++) begin
         $display("[TB] vector %0d opc=%0h rd=%0d rs1=%0d imm=%0h",
                  i, vecs[i].opc, vecs[i].rd, vecs[i].rs1, vecs[i].imm);
         apply_stimulus(vecs[i]);
      end

      // Reset during the third micro-op of imm=3, then re-issue.
      $display("[TB] reset mid-expansion");
      macro_opcode = 7'h2A;
      macro_rd     = 4'd6;
      macro_rs1    = 4'd3;
      macro_imm    = 16'h0003;
      macro_valid  = 1'b1;
      uop_ready    = 1'b1;
      tick();
      macro_valid = 1'b0;
      tick();
      tick();
      check_output("mid_third_uop", dut_uop(),
                   mk_uop(3'd0, 4'd14, 4'd14, 4'd15, '0, 1'b0, 1'b0));
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check_reset_outputs("mid_reset");
      tick();
      check_output("mid_reset_no_done", done, 0);
      check_output("mid_reset_idle", busy, 0);
      apply_stimulus(mk_vec(7'h2A, 4'd6, 4'd3, 16'h0003, -1, 0, -1, 1'b0, 1'b0, 6));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
